// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2
    } arb_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Data-over-fetch priority with a starvation counter that forces a fetch
// grant after STARVE_MAX consecutive data wins.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    localparam int CW        = cnt_width(STARVE_MAX)
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic if_req,
    input  logic mem_req,
    output logic if_gnt,
    output logic mem_gnt
);

    logic [CW-1:0] starve_cnt;
    logic          starve_full;

    assign starve_full = (starve_cnt == CW'(STARVE_MAX));
    assign if_gnt      = ~Resetn & if_req & (~mem_req | starve_full);
    assign mem_gnt     = ~Resetn & mem_req & ~if_gnt;

    // Counts only while fetch is actually waiting behind a data grant.
    always_ff @(posedge Clock) begin
        if (Resetn)
            starve_cnt <= '0;
        else if (mem_gnt & if_req) begin
            if (!starve_full)
                starve_cnt <= starve_cnt + CW'(1);
        end else
            starve_cnt <= '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with a
// one-cycle pipelined read return per side.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              stall,
    output logic              misalign
);

    arb_state_e  state, state_nxt;
    logic [31:0] gnt_addr;
    logic [31:0] if_rdata_q, mem_rdata_q;
    logic        unused_addr;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .if_req  (if_req),
        .mem_req (mem_req),
        .if_gnt  (if_gnt),
        .mem_gnt (mem_gnt)
    );

    assign gnt_addr    = mem_gnt ? mem_addr : if_addr;
    assign ram_en      = if_gnt | mem_gnt;
    assign ram_we      = mem_gnt & mem_we;
    assign ram_addr    = gnt_addr[ADDR_W+1:2];
    assign ram_wdata   = mem_wdata;
    assign misalign    = ram_en & (|gnt_addr[1:0]);
    assign stall       = ~Resetn & ((if_req & ~if_gnt) | (mem_req & ~mem_gnt));
    assign unused_addr = ^gnt_addr;

    always_ff @(posedge Clock) begin
        if (Resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // State names whose read returns next cycle; no dependence on current state.
    always_comb begin
        state_nxt = IDLE;
        if (if_gnt)
            state_nxt = IF_RD;
        else if (mem_gnt & ~mem_we)
            state_nxt = MEM_RD;
    end

    always_comb begin
        if_rvalid  = 1'b0;
        mem_rvalid = 1'b0;
        if (!Resetn) begin
            case (state)
                IF_RD:   if_rvalid  = 1'b1;
                MEM_RD:  mem_rvalid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (if_rvalid)  if_rdata_q  <= ram_rdata;
            if (mem_rvalid) mem_rdata_q <= ram_rdata;
        end
    end

    assign if_rdata  = if_rvalid  ? ram_rdata : if_rdata_q;
    assign mem_rdata = mem_rvalid ? ram_rdata : mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences, then random
// traffic against a transaction-level reference model with a shadow RAM.
module tb_mem_arbiter;

    localparam int SM = 3;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [31:0] ram_rdata = '0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en, ram_we, stall, misalign;
    logic [31:0] if_rdata, mem_rdata, ram_wdata;
    logic [9:0]  ram_addr;

    mem_arbiter dut (
        .Clock(Clock), .Resetn(Resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall(stall), .misalign(misalign)
    );

    always #5 Clock = ~Clock;

    // Behavioural synchronous RAM: read data appears the cycle after the strobe.
    logic [31:0] tb_ram [1024];
    always @(posedge Clock) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    int n_cmp = 0, n_fail = 0, cyc_no = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual=%h required=%h", nm, cyc_no, act, exp);
        end
    endtask

    // Reference model state: transaction level, not cycle-structure of the RTL.
    logic [31:0] shadow [1024];
    int          dwins = 0;
    bit          pend_if = 0, pend_mem = 0;
    logic [31:0] pend_data = '0, held_if = '0, held_mem = '0;

    task automatic cyc(input bit rst, input bit ifr, input logic [31:0] ia,
                       input bit mr, input bit mwe, input logic [31:0] ma,
                       input logic [31:0] mwd);
        bit eifg, emg, een, ewe, estall, emis, eifv, emv;
        logic [31:0] ga, eifd, emd;
        int widx;
        @(negedge Clock);
        cyc_no++;
        Resetn = rst; if_req = ifr; if_addr = ia;
        mem_req = mr; mem_we = mwe; mem_addr = ma; mem_wdata = mwd;
        #1;
        eifg   = !rst && ifr && (!mr || dwins == SM);
        emg    = !rst && mr && !eifg;
        een    = eifg || emg;
        ga     = emg ? ma : ia;
        widx   = int'(ga[11:2]);
        ewe    = emg && mwe;
        estall = !rst && ((ifr && !eifg) || (mr && !emg));
        emis   = een && (ga[1:0] != 2'b00);
        eifv   = !rst && pend_if;
        emv    = !rst && pend_mem;
        eifd   = eifv ? pend_data : held_if;
        emd    = emv  ? pend_data : held_mem;
        cmp("m.if_gnt", if_gnt, eifg);
        cmp("m.mem_gnt", mem_gnt, emg);
        cmp("m.ram_en", ram_en, een);
        cmp("m.ram_we", ram_we, ewe);
        if (een) cmp("m.ram_addr", ram_addr, ga[11:2]);
        cmp("m.ram_wdata", ram_wdata, mwd);
        cmp("m.stall", stall, estall);
        cmp("m.misalign", misalign, emis);
        cmp("m.if_rvalid", if_rvalid, eifv);
        cmp("m.mem_rvalid", mem_rvalid, emv);
        cmp("m.if_rdata", if_rdata, eifd);
        cmp("m.mem_rdata", mem_rdata, emd);
        if (rst) begin
            dwins = 0; pend_if = 0; pend_mem = 0; held_if = '0; held_mem = '0;
        end else begin
            held_if  = eifd;
            held_mem = emd;
            dwins    = (emg && ifr) ? ((dwins < SM) ? dwins + 1 : SM) : 0;
            pend_if  = eifg;
            pend_mem = emg && !mwe;
            if (eifg || (emg && !mwe)) pend_data = shadow[widx];
            if (ewe) shadow[widx] = mwd;
        end
    endtask

    typedef struct {
        int          rst, ifr;
        logic [31:0] ia;
        int          mr, mwe;
        logic [31:0] ma, mwd;
        int          eifg, emg, ewe, eaddr, estall, emis, eifv, emv;
    } vec_t;

    vec_t tbl [17];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tb_ram[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
            shadow[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
        end

        //          rst ifr ia          mr mwe ma          mwd           ifg mg we addr st mis ifv mv
        tbl[0]  = '{1, 1, 32'h10,       0, 0, 32'h0,       32'h0,         0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 1, 32'h10,       0, 0, 32'h0,       32'h0,         1, 0, 0, 4,  0, 0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,       32'h0,         0, 0, 0, 0,  0, 0, 1, 0};
        tbl[3]  = '{0, 1, 32'h14,       1, 0, 32'h20,      32'h0,         0, 1, 0, 8,  1, 0, 0, 0};
        tbl[4]  = '{0, 1, 32'h14,       1, 0, 32'h20,      32'h0,         0, 1, 0, 8,  1, 0, 0, 1};
        tbl[5]  = '{0, 1, 32'h14,       1, 0, 32'h20,      32'h0,         0, 1, 0, 8,  1, 0, 0, 1};
        tbl[6]  = '{0, 1, 32'h14,       1, 0, 32'h20,      32'h0,         1, 0, 0, 5,  1, 0, 0, 1};
        tbl[7]  = '{0, 1, 32'h14,       1, 0, 32'h20,      32'h0,         0, 1, 0, 8,  1, 0, 1, 0};
        tbl[8]  = '{0, 1, 32'h30,       0, 0, 32'h0,       32'h0,         1, 0, 0, 12, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 32'h0,        1, 0, 32'h40,      32'h0,         0, 1, 0, 16, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 32'h44,       0, 0, 32'h0,       32'h0,         1, 0, 0, 17, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 32'h0,        1, 1, 32'h8,       32'hDEADBEEF,  0, 1, 1, 2,  0, 0, 1, 0};
        tbl[12] = '{0, 0, 32'h0,        1, 0, 32'h6,       32'h0,         0, 1, 0, 1,  0, 1, 0, 0};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,       32'h0,         0, 0, 0, 0,  0, 0, 0, 1};
        tbl[14] = '{0, 1, 32'h8,        0, 0, 32'h0,       32'h0,         1, 0, 0, 2,  0, 0, 0, 0};
        tbl[15] = '{1, 1, 32'h8,        0, 0, 32'h0,       32'h0,         0, 0, 0, 0,  0, 0, 0, 0};
        tbl[16] = '{0, 0, 32'h0,        0, 0, 32'h0,       32'h0,         0, 0, 0, 0,  0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rst != 0, tbl[i].ifr != 0, tbl[i].ia, tbl[i].mr != 0,
                tbl[i].mwe != 0, tbl[i].ma, tbl[i].mwd);
            cmp($sformatf("t%0d.if_gnt", i), if_gnt, tbl[i].eifg);
            cmp($sformatf("t%0d.mem_gnt", i), mem_gnt, tbl[i].emg);
            cmp($sformatf("t%0d.ram_we", i), ram_we, tbl[i].ewe);
            if (tbl[i].eifg != 0 || tbl[i].emg != 0)
                cmp($sformatf("t%0d.ram_addr", i), ram_addr, tbl[i].eaddr);
            cmp($sformatf("t%0d.stall", i), stall, tbl[i].estall);
            cmp($sformatf("t%0d.misalign", i), misalign, tbl[i].emis);
            cmp($sformatf("t%0d.if_rvalid", i), if_rvalid, tbl[i].eifv);
            cmp($sformatf("t%0d.mem_rvalid", i), mem_rvalid, tbl[i].emv);
        end
        cmp("t.rdata_after_reset", if_rdata, 32'h0);

        // Sustained contention: three data wins then one fetch, repeating.
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 32'h100, 1, 0, 32'h104, 32'h0);
            cmp($sformatf("h.starve%0d.if_gnt", k), if_gnt, (k % 4) == 3);
            cmp($sformatf("h.starve%0d.stall", k), stall, 1'b1);
        end

        // Data read outstanding when reset hits: its return is dropped.
        cyc(0, 0, 32'h0, 1, 0, 32'h24, 32'h0);
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        cmp("h.rst_drop.mem_rvalid", mem_rvalid, 1'b0);
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        cmp("h.rst_drop.mem_rvalid2", mem_rvalid, 1'b0);
        cmp("h.rst_drop.mem_rdata", mem_rdata, 32'h0);

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the RAM word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 3, giving the maximum number of consecutive data-side wins while fetch waits.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port if_req, input, 1 bit: fetch read request.
REQ-006 SHALL have port if_addr, input, 32 bits: fetch byte address.
REQ-007 SHALL have port if_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid, output, 1 bit: if_rdata valid.
REQ-009 SHALL have port if_rdata, output, 32 bits: fetched instruction.
REQ-010 SHALL have ports mem_req, mem_we, input, 1 bit each: data request and write enable.
REQ-011 SHALL have ports mem_addr and mem_wdata, input, 32 bits each: data byte address and store data.
REQ-012 SHALL have ports mem_gnt and mem_rvalid, output, 1 bit each: data request accepted, and load data valid.
REQ-013 SHALL have port mem_rdata, output, 32 bits: load data.
REQ-014 SHALL have ports ram_en and ram_we, output, 1 bit each: RAM access strobe and write strobe.
REQ-015 SHALL have port ram_addr, output, ADDR_W bits: RAM word address.
REQ-016 SHALL have ports ram_wdata, output, and ram_rdata, input, 32 bits each; ram_rdata is valid the cycle after a read strobe.
REQ-017 SHALL have port stall, output, 1 bit: pipeline freeze request.
REQ-018 SHALL have port misalign, output, 1 bit: granted address has bits [1:0] nonzero.

Function
REQ-019 SHALL issue at most one RAM access per cycle; a grant and its ram_en SHALL occur in the same cycle, combinationally.
REQ-020 SHALL drive ram_addr = granted addr[ADDR_W+1:2]; ram_we = mem_we when the data side is granted, else 0.
REQ-021 SHALL drive ram_wdata = mem_wdata.
REQ-022 SHALL give priority to the data side (mem_req) over fetch when both request.
REQ-023 SHALL instead grant fetch when both request and starve_cnt == STARVE_MAX.
REQ-024 starve_cnt SHALL increment, saturating at STARVE_MAX, when data is granted while if_req is high; it SHALL clear when fetch is granted or if_req is low.
REQ-025 SHALL track the outstanding read with FSM states IDLE, IF_RD and MEM_RD, meaning no read returns, the fetch read returns, or the data read returns this cycle.
REQ-026 FSM next state SHALL be IF_RD after a fetch grant, MEM_RD after a data read grant, and IDLE after a write or no grant; this is independent of the current state (fully pipelined).
REQ-027 In IF_RD, SHALL assert if_rvalid=1 with if_rdata=ram_rdata; in MEM_RD, SHALL assert mem_rvalid=1 with mem_rdata=ram_rdata.
REQ-028 Read latency SHALL be exactly 1 cycle from grant to rvalid; writes produce no rvalid.
REQ-029 rdata of a non-valid side SHALL hold its last returned value.
REQ-030 SHALL drive stall = (if_req & ~if_gnt) | (mem_req & ~mem_gnt), combinationally.
REQ-031 SHALL drive misalign = 1 in the grant cycle if the granted address has bits [1:0] != 0; the access still proceeds, truncated to the word.
REQ-032 Requests SHALL be level-sensitive; an ungranted request is retried each cycle until granted, and no request is queued internally.

Reset
REQ-033 While Resetn=1 at a clock edge: FSM=IDLE, starve_cnt=0, if_rdata=0, mem_rdata=0.
REQ-034 While Resetn=1, all grants, ram_en, ram_we, rvalids, stall and misalign SHALL be 0.
REQ-035 A read outstanding when reset is applied SHALL be dropped, with no rvalid after reset.

Structure
REQ-036 Shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, IF_RD, MEM_RD) and the defaults for ADDR_W and STARVE_MAX.
REQ-037 The priority decision and starve_cnt SHALL reside in one sub-module, mem_arb_prio; the FSM, datapath muxes and rdata registers SHALL remain in mem_arbiter.

Verification
REQ-038 if_req=1, if_addr=0x10 alone -> if_gnt=1, ram_addr=4, stall=0; next cycle if_rvalid=1, if_rdata=ram_rdata.
REQ-039 if_req=mem_req=1 held, mem_we=0 -> mem_gnt for 3 cycles (stall=1), then if_gnt on cycle 4, starve_cnt=0 afterwards.
REQ-040 Back-to-back grants fetch, data read, fetch -> rvalids alternate if, mem, if on consecutive cycles with matching data.
REQ-041 mem_req=1, mem_we=1, mem_addr=0x8, mem_wdata=0xDEADBEEF -> ram_we=1, ram_addr=2, no mem_rvalid next cycle.
REQ-042 mem_addr=0x6 read -> misalign=1, ram_addr=1.
REQ-043 Reset asserted the cycle after a fetch grant -> no if_rvalid, and all outputs 0 in the following cycle.
